axi_wresp_tracker: RTL and testbench

Master-side write-response tracker for the AXI bridge: consumes the B channel (BID/BRESP/BVALID) produced by the slave-side write response generator and drives BREADY. It records every issued write ID on the AW handshake, retires it on the matching B handshake, and forwards completions upstream through a registered completion port. It flags unexpected IDs, table overflow and response timeouts as sticky errors.

---
 rtl/axi_bridge_pkg.sv | 15 +
 rtl/axi_wresp_id_table.sv | 114 +++++++++++
 rtl/axi_wresp_tracker.sv | 131 +++++++++++++
 tb/tb_axi_wresp_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared constants for the AXI bridge: response codes, default ID width and
// the bit positions of the write-response tracker's sticky error vector.
package axi_bridge_pkg;

  localparam int unsigned DEFAULT_ID_W = 6;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_UNEXP = 0;
  localparam int unsigned ERR_TMO   = 1;
  localparam int unsigned ERR_OVF   = 2;

endpackage

// File: rtl/axi_wresp_id_table.sv
// Outstanding-write ID table: ENTRIES slots of {valid, id, cnt}.
// Ports:
//   clk, reset      clock, async active-low reset
//   aw_fire, aw_id  write issued upstream this cycle
//   aw_stall_c      aw_id cannot be accepted (slot full or table full)
//   aw_accept_c     aw_fire qualified by !aw_stall_c
//   b_fire, b_id    B handshake this cycle and its ID
//   b_hit_c         b_id matches a valid slot
module axi_wresp_id_table #(
  parameter int unsigned ID_W    = 6,
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            aw_fire,
  input  logic [ID_W-1:0] aw_id,
  output logic            aw_stall_c,
  output logic            aw_accept_c,
  input  logic            b_fire,
  input  logic [ID_W-1:0] b_id,
  output logic            b_hit_c
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ID_W-1:0]    id_q  [ENTRIES];
  logic [ID_W-1:0]    id_d  [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_d [ENTRIES];

  logic             aw_hit, aw_full, b_hit, free_any;
  logic [IDX_W-1:0] aw_idx, b_idx, free_idx;
  logic [ENTRIES-1:0] slot_inc, slot_dec;

  // Match and free-slot priority encoders; descending scan so the lowest index wins.
  always_comb begin
    aw_hit   = 1'b0;
    aw_full  = 1'b0;
    aw_idx   = '0;
    b_hit    = 1'b0;
    b_idx    = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (id_q[i] == aw_id)) begin
        aw_hit  = 1'b1;
        aw_full = (cnt_q[i] == CNT_MAX);
        aw_idx  = IDX_W'(i);
      end
      if (valid_q[i] && (id_q[i] == b_id)) begin
        b_hit = 1'b1;
        b_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign aw_stall_c  = aw_hit ? aw_full : !free_any;
  assign aw_accept_c = aw_fire && !aw_stall_c;
  assign b_hit_c     = b_hit;

  // Per-slot increment (match or allocation) and decrement (matched retire).
  always_comb begin
    slot_inc = '0;
    slot_dec = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      slot_inc[i] = aw_accept_c &&
                    (aw_hit ? (aw_idx == IDX_W'(i)) : (free_idx == IDX_W'(i)));
      slot_dec[i] = b_fire && b_hit && (b_idx == IDX_W'(i));
    end
  end

  // Slot update; simultaneous inc and dec on one slot cancel, keeping it valid.
  // Free slots always hold cnt==0, so allocation is a plain increment.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (slot_inc[i] && !slot_dec[i]) begin
        valid_d[i] = 1'b1;
        id_d[i]    = aw_id;
        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end else if (slot_dec[i] && !slot_inc[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        if (cnt_q[i] == CNT_W'(1)) begin
          valid_d[i] = 1'b0;
        end
      end
    end
  end

  // Table state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_wresp_tracker.sv
// Master-side AXI write-response tracker: records AW IDs, retires them on B,
// forwards completions through a registered port and flags sticky errors.
// Ports:
//   clk, reset                       clock, async active-low reset
//   aw_fire, aw_id, aw_stall         AW issue and back-pressure (aw_stall comb)
//   BID, BRESP, BVALID, BREADY       B channel (BREADY comb from cmpl_ready)
//   cmpl_valid/id/resp, cmpl_ready   registered completion port
//   outstanding                      total writes in flight
//   err, err_clr                     sticky {overflow, timeout, unexpected BID}
module axi_wresp_tracker
  import axi_bridge_pkg::*;
#(
  parameter int unsigned ID_W        = DEFAULT_ID_W,
  parameter int unsigned ENTRIES     = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              aw_fire,
  input  logic [ID_W-1:0]                   aw_id,
  output logic                              aw_stall,
  input  logic [ID_W-1:0]                   BID,
  input  logic                              BRESP,
  input  logic                              BVALID,
  output logic                              BREADY,
  output logic                              cmpl_valid,
  output logic [ID_W-1:0]                   cmpl_id,
  output logic                              cmpl_resp,
  input  logic                              cmpl_ready,
  output logic [CNT_W+$clog2(ENTRIES)-1:0]  outstanding,
  output logic [2:0]                        err,
  input  logic                              err_clr
);

  localparam int unsigned OUT_W = CNT_W + $clog2(ENTRIES);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);

  logic             cmpl_valid_q, cmpl_valid_d;
  logic [ID_W-1:0]  cmpl_id_q, cmpl_id_d;
  logic             cmpl_resp_q, cmpl_resp_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic b_fire_c, b_hit_c, aw_stall_c, aw_accept_c, b_retire_c;

  assign BREADY     = !cmpl_valid_q || cmpl_ready;
  assign b_fire_c   = BVALID && BREADY;
  assign b_retire_c = b_fire_c && b_hit_c;

  axi_wresp_id_table #(
    .ID_W    (ID_W),
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) u_id_table (
    .clk         (clk),
    .reset       (reset),
    .aw_fire     (aw_fire),
    .aw_id       (aw_id),
    .aw_stall_c  (aw_stall_c),
    .aw_accept_c (aw_accept_c),
    .b_fire      (b_fire_c),
    .b_id        (BID),
    .b_hit_c     (b_hit_c)
  );

  assign aw_stall = aw_stall_c;

  // Completion register, in-flight counter, progress timer and sticky errors.
  always_comb begin
    cmpl_valid_d  = cmpl_valid_q;
    cmpl_id_d     = cmpl_id_q;
    cmpl_resp_d   = cmpl_resp_q;
    outstanding_d = outstanding_q;
    tmo_d         = tmo_q;
    err_d         = err_clr ? '0 : err_q;

    // A retire in the same cycle as a consume reloads back-to-back.
    if (b_retire_c) begin
      cmpl_valid_d = 1'b1;
      cmpl_id_d    = BID;
      cmpl_resp_d  = BRESP;
    end else if (cmpl_ready) begin
      cmpl_valid_d = 1'b0;
    end

    case ({aw_accept_c, b_retire_c})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Counts cycles of no B progress while writes are in flight; saturates.
    if (b_fire_c || (outstanding_q == '0)) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (b_fire_c && !b_hit_c) err_d[ERR_UNEXP] = 1'b1;
    if ((tmo_q != TMO_MAX) && (tmo_d == TMO_MAX)) err_d[ERR_TMO] = 1'b1;
    if (aw_fire && aw_stall_c) err_d[ERR_OVF] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmpl_valid_q  <= 1'b0;
      cmpl_id_q     <= '0;
      cmpl_resp_q   <= RESP_OKAY;
      outstanding_q <= '0;
      tmo_q         <= '0;
      err_q         <= '0;
    end else begin
      cmpl_valid_q  <= cmpl_valid_d;
      cmpl_id_q     <= cmpl_id_d;
      cmpl_resp_q   <= cmpl_resp_d;
      outstanding_q <= outstanding_d;
      tmo_q         <= tmo_d;
      err_q         <= err_d;
    end
  end

  assign cmpl_valid  = cmpl_valid_q;
  assign cmpl_id     = cmpl_id_q;
  assign cmpl_resp   = cmpl_resp_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule

// File: tb/tb_axi_wresp_tracker.sv
// Bench for axi_wresp_tracker: directed scenarios plus random traffic, checked
// against an ID->count map model; completions go through a scoreboard queue.
module tb_axi_wresp_tracker;

  localparam int ID_W        = 6;
  localparam int ENTRIES     = 4;
  localparam int CNT_W       = 4;
  localparam int TIMEOUT_CYC = 1024;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  aw_fire;
  logic [ID_W-1:0]       aw_id;
  logic                  aw_stall;
  logic [ID_W-1:0]       BID;
  logic                  BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic                  cmpl_valid;
  logic [ID_W-1:0]       cmpl_id;
  logic                  cmpl_resp;
  logic                  cmpl_ready;
  logic [CNT_W+1:0]      outstanding;
  logic [2:0]            err;
  logic                  err_clr;

  always #5 clk = ~clk;

  axi_wresp_tracker #(
    .ID_W        (ID_W),
    .ENTRIES     (ENTRIES),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .aw_fire     (aw_fire),
    .aw_id       (aw_id),
    .aw_stall    (aw_stall),
    .BID         (BID),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .cmpl_valid  (cmpl_valid),
    .cmpl_id     (cmpl_id),
    .cmpl_resp   (cmpl_resp),
    .cmpl_ready  (cmpl_ready),
    .outstanding (outstanding),
    .err         (err),
    .err_clr     (err_clr)
  );

  typedef struct {
    int id;
    int resp;
  } cmpl_t;

  // Reference model: outstanding count per ID, expected completions in order.
  cmpl_t      exp_q[$];
  int         cnt[int];
  int         total;
  int         streak;
  logic [2:0] exp_err;
  bit         exp_bready_s;
  cmpl_t      mon_e;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic bit m_stall(input int id);
    if (cnt.exists(id)) return cnt[id] == CNT_MAX;
    return cnt.num() == ENTRIES;
  endfunction

  function automatic void model_reset();
    cnt.delete();
    exp_q.delete();
    total   = 0;
    streak  = 0;
    exp_err = '0;
  endfunction

  task automatic check_outputs();
    exp_bready_s = (exp_q.size() == 0) || (cmpl_ready == 1'b1);
    chk("aw_stall", 32'(aw_stall), 32'(m_stall(int'(aw_id))));
    chk("BREADY", 32'(BREADY), 32'(exp_bready_s));
    chk("outstanding", 32'(outstanding), 32'(total));
    chk("err", 32'(err), 32'(exp_err));
    chk("cmpl_valid", 32'(cmpl_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("cmpl_id_held", 32'(cmpl_id), 32'(exp_q[0].id));
      chk("cmpl_resp_held", 32'(cmpl_resp), 32'(exp_q[0].resp));
    end
  endtask

  // Applies this cycle's inputs to the model at the clock edge.
  task automatic model_update();
    int  aid;
    int  bid;
    bit  stall;
    bit  acc;
    bit  bf;
    bit  hit;
    aid   = int'(aw_id);
    bid   = int'(BID);
    stall = m_stall(aid);
    acc   = aw_fire && !stall;
    bf    = BVALID && exp_bready_s;
    hit   = cnt.exists(bid);
    if (err_clr) exp_err = '0;
    if (bf && !hit) exp_err[0] = 1'b1;
    if (aw_fire && stall) exp_err[2] = 1'b1;
    if (bf || total == 0) streak = 0;
    else begin
      streak++;
      if (streak == TIMEOUT_CYC - 1) exp_err[1] = 1'b1;
    end
    if (acc) begin
      if (cnt.exists(aid)) cnt[aid]++;
      else cnt[aid] = 1;
      total++;
    end
    if (bf && hit) begin
      cnt[bid]--;
      if (cnt[bid] == 0) cnt.delete(bid);
      total--;
      exp_q.push_back('{bid, int'(BRESP)});
    end
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input bit af, input int aid, input bit bv, input int bid,
                      input bit br, input bit cr, input bit ec);
    aw_fire    = af;
    aw_id      = ID_W'(aid);
    BVALID     = bv;
    BID        = ID_W'(bid);
    BRESP      = br;
    cmpl_ready = cr;
    err_clr    = ec;
    #2;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset      = 1'b0;
    aw_fire    = 1'b0;
    aw_id      = '0;
    BVALID     = 1'b0;
    BID        = '0;
    BRESP      = 1'b0;
    cmpl_ready = 1'b1;
    err_clr    = 1'b0;
    model_reset();
    #2;
    check_outputs();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every consumed completion must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && cmpl_valid === 1'b1 && cmpl_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL cmpl_unexpected: got id %0h with no completion expected at %0t",
                   cmpl_id, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmpl_id", 32'(cmpl_id), 32'(mon_e.id));
          chk("cmpl_resp", 32'(cmpl_resp), 32'(mon_e.resp));
        end
      end
    end
  end

  initial begin
    int  keys[$];
    int  aid;
    int  bid;
    bit  af;
    bit  bv;

    reset = 1'b1;
    #1;
    do_reset(3);

    // Single write and its OKAY response.
    step(1, 5, 0, 0, 0, 1, 0);
    step(0, 0, 1, 5, 0, 1, 0);
    idle(2);

    // Fill the table with four IDs, then a fifth is stalled and flagged.
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0, 1, 0);
    step(0, 7, 0, 0, 0, 1, 0);
    step(1, 7, 0, 0, 0, 1, 0);
    step(0, 7, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, i, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Per-ID counter saturation on id 3; other IDs still accepted.
    for (int i = 0; i < CNT_MAX; i++) step(1, 3, 0, 0, 0, 1, 0);
    step(0, 3, 0, 0, 0, 1, 0);
    step(0, 4, 0, 0, 0, 1, 0);
    step(0, 3, 1, 3, 0, 1, 0);
    step(0, 3, 0, 0, 0, 1, 0);
    for (int i = 0; i < CNT_MAX - 1; i++) step(0, 3, 1, 3, 0, 1, 0);
    idle(2);

    // Same-cycle AW and B on one ID at count 1: slot survives.
    step(1, 6, 0, 0, 0, 1, 0);
    step(1, 6, 1, 6, 0, 1, 0);
    step(0, 6, 0, 0, 0, 1, 0);
    step(0, 0, 1, 6, 1, 1, 0);
    idle(2);

    // Back-pressure: completion held while cmpl_ready is low, then back-to-back.
    step(1, 2, 0, 0, 0, 1, 0);
    step(1, 2, 0, 0, 0, 1, 0);
    step(0, 0, 1, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 1, 2, 0, 1, 0);
    idle(2);

    // Unexpected BID, clear, and set-wins-over-clear.
    step(0, 0, 1, 9, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 9, 0, 1, 0);
    step(0, 0, 1, 9, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Timeout with one write outstanding, then reset mid-run.
    step(1, 1, 0, 0, 0, 1, 0);
    idle(TIMEOUT_CYC + 4);
    do_reset(2);
    idle(2);

    // Random traffic over a small ID pool to exercise stalls and reuse.
    for (int c = 0; c < 4000; c++) begin
      aid = int'($urandom_range(0, 7));
      af  = ($urandom_range(0, 99) < 45);
      if (af && m_stall(aid) && ($urandom_range(0, 9) != 0)) af = 1'b0;
      bv  = ($urandom_range(0, 99) < 50);
      keys.delete();
      foreach (cnt[k]) keys.push_back(k);
      if (keys.size() > 0 && $urandom_range(0, 99) < 92)
        bid = keys[$urandom_range(0, keys.size() - 1)];
      else
        bid = int'($urandom_range(0, 15));
      step(af, aid, bv, bid, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 3));
      if (c == 2500) do_reset(1);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
